// File: rtl/display_pkg.sv
// Shared types and constants for the BCD display formatter.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned BCD_DIGITS   = 3;
  localparam int unsigned SHIFT_CYCLES = 8;

  // Field offsets inside the 32-bit value bus
  localparam int unsigned DEC_LSB = 0;
  localparam int unsigned AUX_LSB = 16;
  localparam int unsigned RAW_LSB = 24;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // Pre-shift correction so the digit carries correctly into the next one
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= DIGIT_W'(5)) begin
      o_digit = i_digit + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd_display_formatter.sv
// Sequential double-dabble converter feeding the 8-digit seven-segment driver.
// Optional macro DISP_HEX_FIELD_EN adds a hex view (raw byte + aux byte) in
// value[31:16]; without it those bits are zero and aux_in is ignored.
module bcd_display_formatter
  import display_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned AUTO_LOAD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] data_in,
  input  logic [7:0]      aux_in,
  input  logic            signed_mode,
  input  logic            load,
  output logic [31:0]     value,
  output logic            neg,
  output logic            busy,
  output logic            valid
);

  localparam int unsigned BcdW = DIGIT_W * BCD_DIGITS;

  state_t            r_state;
  state_t            w_state_next;
  logic [IN_W-1:0]   r_mag;
  logic [BcdW-1:0]   r_bcd;
  logic [3:0]        r_cnt;
  logic              r_neg_n;
  logic [IN_W-1:0]   r_last;
  logic              r_pending;
  logic [31:0]       r_value;
  logic              r_neg;
  logic              r_valid;

  logic              w_start;
  logic              w_capture;
  logic              w_last_shift;
  logic              w_neg_in;
  logic [IN_W-1:0]   w_mag_in;
  logic [BcdW-1:0]   w_adj;
  logic [31:0]       w_commit_value;

`ifdef DISP_HEX_FIELD_EN
  logic [7:0]        r_aux;
  logic [7:0]        r_raw;
`else
  logic              w_unused_aux;
  assign w_unused_aux = ^aux_in;
`endif

  assign w_start      = load | ((AUTO_LOAD != 0) && (data_in != r_last));
  // A commit with a request outstanding (or arriving) chains straight into a new capture
  assign w_capture    = ((r_state == IDLE) && w_start) ||
                        ((r_state == COMMIT) && (r_pending || w_start));
  assign w_last_shift = (r_cnt == 4'(SHIFT_CYCLES - 1));
  assign w_neg_in     = signed_mode & data_in[IN_W-1];
  // 0x80 negates to itself, which reads correctly as unsigned 128
  assign w_mag_in     = w_neg_in ? (~data_in + IN_W'(1)) : data_in;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_bcd[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Assemble the word presented at commit
  always_comb begin
    w_commit_value = '0;
    w_commit_value[DEC_LSB +: BcdW] = r_bcd;
`ifdef DISP_HEX_FIELD_EN
    w_commit_value[AUX_LSB +: 8] = r_aux;
    w_commit_value[RAW_LSB +: 8] = r_raw;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_state_next = SHIFT;
      SHIFT:   if (w_last_shift) w_state_next = COMMIT;
      COMMIT:  w_state_next = w_capture ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy  = (r_state != IDLE);
    value = r_value;
    neg   = r_neg;
    valid = r_valid;
  end

  // Datapath: capture, shift-and-adjust, commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_neg_n   <= 1'b0;
      r_last    <= '0;
      r_pending <= 1'b0;
      r_value   <= '0;
      r_neg     <= 1'b0;
      r_valid   <= 1'b0;
`ifdef DISP_HEX_FIELD_EN
      r_aux     <= '0;
      r_raw     <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_capture) begin
        r_mag     <= w_mag_in;
        r_neg_n   <= w_neg_in;
        r_last    <= data_in;
        r_bcd     <= '0;
        r_cnt     <= '0;
        r_pending <= 1'b0;
`ifdef DISP_HEX_FIELD_EN
        r_aux     <= aux_in;
        r_raw     <= data_in[7:0];
`endif
      end else if (r_state == SHIFT) begin
        r_bcd <= {w_adj[BcdW-2:0], r_mag[IN_W-1]};
        r_mag <= {r_mag[IN_W-2:0], 1'b0};
        r_cnt <= r_cnt + 4'd1;
        if (w_start) r_pending <= 1'b1;
      end
      if (r_state == COMMIT) begin
        r_value <= w_commit_value;
        r_neg   <= r_neg_n;
        r_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Scoreboard bench for bcd_display_formatter (manual-load and auto-load instances).
module tb_bcd_display_formatter;

  typedef struct {
    logic [31:0] v;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = '0;
  logic [7:0]  aux_in = '0;
  logic        signed_mode = 1'b0;
  logic        load = 1'b0;
  logic [31:0] value;
  logic        neg, busy, valid;

  logic [7:0]  data_in_a = '0;
  logic [31:0] value_a;
  logic        neg_a, busy_a, valid_a;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int valid_cnt = 0;
  int valid_cnt_a = 0;
  logic valid_prev = 1'b0;

  exp_t sb[$];
  exp_t sb_a[$];

  always #5 clk = ~clk;

  bcd_display_formatter #(.IN_W(8), .AUTO_LOAD(0)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .aux_in      (aux_in),
    .signed_mode (signed_mode),
    .load        (load),
    .value       (value),
    .neg         (neg),
    .busy        (busy),
    .valid       (valid)
  );

  bcd_display_formatter #(.IN_W(8), .AUTO_LOAD(1)) u_dut_auto (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in_a),
    .aux_in      (8'h00),
    .signed_mode (1'b0),
    .load        (1'b0),
    .value       (value_a),
    .neg         (neg_a),
    .busy        (busy_a),
    .valid       (valid_a)
  );

  function automatic logic [31:0] exp_val(input logic [11:0] bcd, input logic [7:0] raw,
                                          input logic [7:0] aux);
`ifdef DISP_HEX_FIELD_EN
    return {raw, aux, 4'h0, bcd};
`else
    return {20'h0, bcd};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] bcd, input logic [7:0] raw, input logic [7:0] aux,
                      input logic n);
    exp_t e;
    e.v = exp_val(bcd, raw, aux);
    e.n = n;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] d, input logic s, input logic [7:0] a);
    @(negedge clk);
    data_in     = d;
    signed_mode = s;
    aux_in      = a;
    load        = 1'b1;
    @(negedge clk);
    load        = 1'b0;
  endtask

  // Monitor for the manual-load instance
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (valid) begin
      valid_cnt++;
      if (valid_prev) begin
        checks++;
        errors++;
        $display("FAIL valid_width: got 2+ cycles required 1");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got value 0x%08h required no commit", value);
      end else begin
        e = sb.pop_front();
        chk("value", value, e.v);
        chk("neg", {31'h0, neg}, {31'h0, e.n});
      end
    end
    valid_prev = valid;
  end

  // Monitor for the auto-load instance
  always @(negedge clk) begin
    exp_t e;
    if (valid_a) begin
      valid_cnt_a++;
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL auto_unexpected_valid: got value 0x%08h required no commit", value_a);
      end else begin
        e = sb_a.pop_front();
        chk("auto_value", value_a, e.v);
        chk("auto_neg", {31'h0, neg_a}, {31'h0, e.n});
      end
    end
  end

  initial begin
    exp_t ea;
    repeat (3) @(negedge clk);
    chk("rst_value", value, 32'h0);
    chk("rst_neg", {31'h0, neg}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_auto_busy", {31'h0, busy_a}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unsigned 255
    busy_cnt = 0;
    valid_cnt = 0;
    push(12'h255, 8'hFF, 8'h00, 1'b0);
    do_load(8'hFF, 1'b0, 8'h00);
    repeat (14) @(negedge clk);
    chk("busy_cycles_ff", busy_cnt, 9);
    chk("valid_pulses_ff", valid_cnt, 1);

    // Signed minimum and -1
    push(12'h128, 8'h80, 8'h00, 1'b1);
    do_load(8'h80, 1'b1, 8'h00);
    repeat (14) @(negedge clk);
    push(12'h001, 8'hFF, 8'h00, 1'b1);
    do_load(8'hFF, 1'b1, 8'h00);
    repeat (14) @(negedge clk);

    // Zero
    valid_cnt = 0;
    push(12'h000, 8'h00, 8'h00, 1'b0);
    do_load(8'h00, 1'b0, 8'h00);
    repeat (14) @(negedge clk);
    chk("valid_pulses_zero", valid_cnt, 1);

    // Back-to-back: second load lands at edge k+3
    busy_cnt = 0;
    valid_cnt = 0;
    push(12'h042, 8'h2A, 8'h00, 1'b0);
    push(12'h099, 8'h63, 8'h00, 1'b0);
    do_load(8'h2A, 1'b0, 8'h00);
    @(negedge clk);
    do_load(8'h63, 1'b0, 8'h00);
    repeat (25) @(negedge clk);
    chk("valid_pulses_b2b", valid_cnt, 2);
    chk("busy_cycles_b2b", busy_cnt, 18);

    // Reset at edge k+4 aborts the conversion
    valid_cnt = 0;
    do_load(8'hC8, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_value", value, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_valid", {31'h0, valid}, 32'h0);
    repeat (15) @(negedge clk);
    chk("abort_no_commit", valid_cnt, 0);

    // Hex field view
    push(12'h200, 8'hC8, 8'h3F, 1'b0);
    do_load(8'hC8, 1'b0, 8'h3F);
    repeat (14) @(negedge clk);

    // Auto-load on operand change
    ea.v = exp_val(12'h007, 8'h07, 8'h00);
    ea.n = 1'b0;
    sb_a.push_back(ea);
    data_in_a = 8'h07;
    repeat (14) @(negedge clk);
    chk("auto_valid_pulses", valid_cnt_a, 1);

    chk("sb_drained", sb.size(), 0);
    chk("auto_sb_drained", sb_a.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_formatter.md
Name: bcd_display_formatter

Overview:
- Upstream feeder of the 8-digit seven-segment driver.
- Converts the CPU output register (8-bit, unsigned or two's-complement) into packed BCD digits on the driver's 32-bit `value` bus.
- Uses a sequential double-dabble engine with load/busy/valid handshake.
- `value` is held stable between conversions, so the display never shows partial results.

Parameters:
- IN_W, 8, operand width; fixed at 8 for this revision (3 BCD digits).
- AUTO_LOAD, 0, 1 = start a conversion whenever `data_in` differs from the last captured operand; 0 = start only on `load`.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  operand (CPU output register).
- aux_in  input  8  auxiliary byte; used only with the optional feature.
- signed_mode  input  1  1 = treat `data_in` as two's complement.
- load  input  1  conversion request, sampled each clk.
- value  output  32  packed nibbles to the seven-seg driver.
- neg  output  1  sign of the displayed number (drives an LED).
- busy  output  1  conversion in progress.
- valid  output  1  one-cycle pulse when `value` is updated.

Behaviour:
- Reset (rst=1 at an edge): value=0, neg=0, busy=0, valid=0, state=IDLE, pending=0, shift/count regs cleared, last-operand reg=0. Reset mid-conversion aborts; nothing is committed.
- States: IDLE -> SHIFT -> COMMIT -> IDLE.
- Start condition: `load`=1, or (AUTO_LOAD=1 and `data_in` != last operand).
- IDLE, start at edge k:
  - capture operand: mag = (signed_mode & data_in[7]) ? -data_in : data_in, as 8-bit unsigned; 0x80 gives 128.
  - capture neg_n = signed_mode & data_in[7]; store `data_in` as last operand; clear BCD reg; cnt=0.
  - go to SHIFT.
- SHIFT, edges k+1..k+8, one per bit, MSB first:
  - each BCD digit >= 5 gets +3 (12-bit BCD reg, 3 digits).
  - then shift {bcd, mag} left 1; cnt++.
  - after the 8th shift, go to COMMIT.
- COMMIT, edge k+9:
  - value[11:0] = BCD; value[15:12] = 0; value[31:16] per optional feature; neg = neg_n.
  - valid=1 for exactly the cycle after edge k+9.
  - if pending: clear it and go straight to capture from current inputs (next edge = new k); else go to IDLE.
- Latency: start sampled at edge k -> `value` new after edge k+9.
- busy = (state != IDLE); high after edge k through the COMMIT cycle.
- `load` in SHIFT/COMMIT sets pending (single flag; multiple loads collapse). The re-conversion samples `data_in` at its own capture edge, i.e. the latest value.
- AUTO_LOAD mismatch during busy likewise sets pending.
- `valid` is never high in IDLE unless a COMMIT just occurred. `value` changes only at COMMIT or reset.
- Inputs are not registered beyond capture; `data_in` may change freely during SHIFT.

Optional Feature:
- Macro: DISP_HEX_FIELD_EN.
- Defined: at COMMIT, value[23:16] = aux_in captured at the capture edge; value[31:24] = raw `data_in` byte captured at the same edge (hex view on the left four digits).
- Undefined: value[31:16] = 0; `aux_in` is unused; no capture registers are built.

Decomposition:
- Package display_pkg:
  - state enum {IDLE, SHIFT, COMMIT};
  - DIGIT_W=4, BCD_DIGITS=3, SHIFT_CYCLES=8;
  - field offsets DEC_LSB=0, AUX_LSB=16, RAW_LSB=24.
- One natural sub-module: bcd_digit_adjust, a combinational per-digit "+3 if >=5" cell, instantiated 3 times.

Test Plan:
- Unsigned: load with data_in=0xFF, signed_mode=0 -> after edge k+9, value=0x00000255, neg=0, valid high exactly 1 cycle, busy high 9 cycles.
- Signed min: data_in=0x80, signed_mode=1 -> value=0x00000128, neg=1. Then data_in=0xFF -> value=0x00000001, neg=1.
- Zero/back-to-back: data_in=0x00 -> value=0x00000000, valid pulses. Then load 0x2A, then load 0x63 at edge k+3 -> first commit 0x00000042, second starts without returning to IDLE, commit 0x00000099; exactly two valid pulses.
- Reset mid-op: start 0xC8, assert rst at edge k+4 -> value=0, busy=0, valid=0 next cycle; no later commit. With AUTO_LOAD=1, a change of data_in from 0 to 0x07 with load=0 -> value=0x00000007.
- DISP_HEX_FIELD_EN defined: data_in=0xC8, aux_in=0x3F, signed_mode=0 -> value=0xC83F0200. Undefined: same stimulus -> value=0x00000200.
